// File: rtl/pr_hssi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pr_hssi_link_ctrl
// Brief    : Bring-up and supervision sequencer for the AFU-side HSSI link.
//            Orders TX/RX analog and digital resets against PLL lock,
//            calibration, CDR lock and block lock, retries on timeout and
//            reports link_up / link_fail.
// Options  : PR_HSSI_LINK_CTRL_AUTO_RECOVER_EN - when defined, block-lock loss
//            in UP re-runs the RX bring-up instead of failing the link.
// Revision : 1.0 - initial release
// ============================================================================
module pr_hssi_link_ctrl #(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned RST_CYCLES    = 16,
  parameter logic [19:0] TIMEOUT       = 20'd100000,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                 pClk,
  input  logic                 pck_cp2af_softReset,
  input  logic                 start,
  input  logic                 init_done,
  input  logic                 tx_pll_locked,
  input  logic                 tx_cal_busy,
  input  logic                 rx_cal_busy,
  input  logic [NUM_LANES-1:0] rx_is_lockedtodata,
  input  logic [NUM_LANES-1:0] rx_enh_blk_lock,
  output logic                 tx_analogreset,
  output logic                 tx_digitalreset,
  output logic                 rx_analogreset,
  output logic                 rx_digitalreset,
  output logic                 link_up,
  output logic                 link_fail,
  output logic [1:0]           retry_cnt,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_TX_ARST  = 4'd1,
    ST_TX_WAIT  = 4'd2,
    ST_TX_DRST  = 4'd3,
    ST_RX_ARST  = 4'd4,
    ST_RX_WAIT  = 4'd5,
    ST_RX_DRST  = 4'd6,
    ST_BLK_WAIT = 4'd7,
    ST_UP       = 4'd8,
    ST_FAIL     = 4'd9
  } state_t;

  // Terminal counts: a state lasts N cycles when it leaves at count N-1.
  localparam logic [19:0] RST_LAST    = 20'(RST_CYCLES - 1);
  localparam logic [19:0] TMO_LAST    = TIMEOUT - 20'd1;
  localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [19:0] timer;
  logic [19:0] stable_cnt;
  logic        retry_req;
  logic        retry_ok;
  logic [1:0]  retry_inc;
  logic        all_cdr;
  logic        all_blk;
  logic        pll_lost;
  logic        hold_done;
  logic        timed_out;
  logic [3:0]  rst_vec_nxt;

  assign all_cdr   = &rx_is_lockedtodata;
  assign all_blk   = &rx_enh_blk_lock;
  assign hold_done = (timer == RST_LAST);
  assign timed_out = (timer == TMO_LAST);
  // Once the RX side is being brought up, the TX PLL must stay locked.
  assign pll_lost  = !tx_pll_locked && (state >= ST_RX_ARST) && (state <= ST_UP);
  assign retry_ok  = (32'(retry_cnt) < MAX_RETRY);
  assign retry_inc = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
  assign state_o   = state;

  // Next-state selection in priority order: start, PLL loss, state condition, timeout.
  always_comb begin
    state_nxt = state;
    retry_req = 1'b0;
    if (state == ST_FAIL) begin
      state_nxt = ST_FAIL;
    end else if (!start) begin
      state_nxt = ST_IDLE;
    end else if (pll_lost) begin
      retry_req = 1'b1;
    end else begin
      case (state)
        ST_IDLE:     if (init_done) state_nxt = ST_TX_ARST;
        ST_TX_ARST:  if (hold_done) state_nxt = ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (tx_pll_locked && !tx_cal_busy) state_nxt = ST_TX_DRST;
          else if (timed_out)                retry_req = 1'b1;
        end
        ST_TX_DRST:  if (hold_done) state_nxt = ST_RX_ARST;
        ST_RX_ARST:  if (hold_done) state_nxt = ST_RX_WAIT;
        ST_RX_WAIT: begin
          if (!rx_cal_busy && all_cdr) state_nxt = ST_RX_DRST;
          else if (timed_out)          retry_req = 1'b1;
        end
        ST_RX_DRST:  if (hold_done) state_nxt = ST_BLK_WAIT;
        ST_BLK_WAIT: begin
          if (all_blk && (stable_cnt == STABLE_LAST)) state_nxt = ST_UP;
          else if (timed_out)                         retry_req = 1'b1;
        end
        ST_UP: begin
          if (!all_blk) begin
`ifdef PR_HSSI_LINK_CTRL_AUTO_RECOVER_EN
            state_nxt = ST_RX_ARST;
`else
            state_nxt = ST_FAIL;
`endif
          end
        end
        default:     state_nxt = ST_IDLE;
      endcase
    end
    if (retry_req) state_nxt = retry_ok ? ST_TX_ARST : ST_FAIL;
  end

  // Reset pattern {tx_analog, tx_digital, rx_analog, rx_digital} for the state being entered.
  always_comb begin
    rst_vec_nxt = 4'b1111;
    case (state_nxt)
      ST_TX_WAIT, ST_TX_DRST: rst_vec_nxt = 4'b0111;
      ST_RX_ARST:             rst_vec_nxt = 4'b0011;
      ST_RX_WAIT, ST_RX_DRST: rst_vec_nxt = 4'b0001;
      ST_BLK_WAIT, ST_UP:     rst_vec_nxt = 4'b0000;
      default:                rst_vec_nxt = 4'b1111;
    endcase
  end

  // State, timers, retry counter and registered outputs.
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      state           <= ST_IDLE;
      timer           <= '0;
      stable_cnt      <= '0;
      retry_cnt       <= 2'd0;
      tx_analogreset  <= 1'b1;
      tx_digitalreset <= 1'b1;
      rx_analogreset  <= 1'b1;
      rx_digitalreset <= 1'b1;
      link_up         <= 1'b0;
      link_fail       <= 1'b0;
    end else begin
      state <= state_nxt;
      // The timeout timer runs across block-lock drops; only a state change clears it.
      timer <= (state_nxt != state) ? '0 : timer + 20'd1;
      // Consecutive all-lanes-locked cycles within one BLK_WAIT visit.
      if ((state == ST_BLK_WAIT) && (state_nxt == ST_BLK_WAIT) && all_blk)
        stable_cnt <= stable_cnt + 20'd1;
      else
        stable_cnt <= '0;
      if (state_nxt == ST_IDLE)
        retry_cnt <= 2'd0;
      else if (retry_req && retry_ok)
        retry_cnt <= retry_inc;
      tx_analogreset  <= rst_vec_nxt[3];
      tx_digitalreset <= rst_vec_nxt[2];
      rx_analogreset  <= rst_vec_nxt[1];
      rx_digitalreset <= rst_vec_nxt[0];
      link_up         <= (state_nxt == ST_UP);
      link_fail       <= (state_nxt == ST_FAIL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pr_hssi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pr_hssi_link_ctrl
// Brief    : Self-checking bench for pr_hssi_link_ctrl. Directed bring-up
//            scenarios followed by randomized status traffic, all compared
//            cycle by cycle against a phase/deadline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pr_hssi_link_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int TIMEOUT       = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  // Phase numbers are the published debug encodings.
  localparam int P_IDLE = 0, P_TX_ARST = 1, P_TX_WAIT = 2, P_TX_DRST = 3, P_RX_ARST = 4;
  localparam int P_RX_WAIT = 5, P_RX_DRST = 6, P_BLK_WAIT = 7, P_UP = 8, P_FAIL = 9;

  logic       pClk = 1'b0;
  logic       rst  = 1'b1;
  logic       start = 1'b0;
  logic       init_done = 1'b1;
  logic       tx_pll_locked = 1'b1;
  logic       tx_cal_busy = 1'b0;
  logic       rx_cal_busy = 1'b0;
  logic [3:0] rx_is_lockedtodata = 4'hF;
  logic [3:0] rx_enh_blk_lock = 4'hF;
  logic       tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
  logic       link_up, link_fail;
  logic [1:0] retry_cnt;
  logic [3:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: current phase, cycles spent in it, lock run length, retries used.
  int m_phase = P_IDLE;
  int m_age   = 0;
  int m_run   = 0;
  int m_retry = 0;

  always #5 pClk = ~pClk;

  pr_hssi_link_ctrl #(
    .NUM_LANES    (4),
    .RST_CYCLES   (RST_CYCLES),
    .TIMEOUT      (20'd32),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .pClk               (pClk),
    .pck_cp2af_softReset(rst),
    .start              (start),
    .init_done          (init_done),
    .tx_pll_locked      (tx_pll_locked),
    .tx_cal_busy        (tx_cal_busy),
    .rx_cal_busy        (rx_cal_busy),
    .rx_is_lockedtodata (rx_is_lockedtodata),
    .rx_enh_blk_lock    (rx_enh_blk_lock),
    .tx_analogreset     (tx_analogreset),
    .tx_digitalreset    (tx_digitalreset),
    .rx_analogreset     (rx_analogreset),
    .rx_digitalreset    (rx_digitalreset),
    .link_up            (link_up),
    .link_fail          (link_fail),
    .retry_cnt          (retry_cnt),
    .state_o            (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Which resets each phase leaves asserted, {tx_a, tx_d, rx_a, rx_d}.
  function automatic logic [3:0] phase_resets(input int p);
    if (p == P_IDLE || p == P_TX_ARST || p == P_FAIL) return 4'b1111;
    if (p == P_TX_WAIT || p == P_TX_DRST)             return 4'b0111;
    if (p == P_RX_ARST)                               return 4'b0011;
    if (p == P_RX_WAIT || p == P_RX_DRST)             return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [11:0] model_outs();
    return {4'(m_phase), phase_resets(m_phase), 1'(m_phase == P_UP),
            1'(m_phase == P_FAIL), 2'(m_retry)};
  endfunction

  function automatic logic [11:0] dut_outs();
    return {state_o, tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset,
            link_up, link_fail, retry_cnt};
  endfunction

  // Advance the model by one clock using the inputs presented at this edge.
  task automatic model_step();
    int  nxt;
    bit  want_retry;
    bit  cdr_ok, blk_ok, deadline;
    cdr_ok     = (rx_is_lockedtodata == 4'hF);
    blk_ok     = (rx_enh_blk_lock == 4'hF);
    deadline   = (m_age == TIMEOUT - 1);
    nxt        = m_phase;
    want_retry = 0;
    if (rst) begin
      m_phase = P_IDLE; m_age = 0; m_run = 0; m_retry = 0;
      return;
    end
    if (m_phase == P_FAIL) nxt = P_FAIL;
    else if (!start) nxt = P_IDLE;
    else if (!tx_pll_locked && m_phase >= P_RX_ARST && m_phase <= P_UP) want_retry = 1;
    else if (m_phase == P_IDLE) begin
      if (init_done) nxt = P_TX_ARST;
    end else if (m_phase == P_TX_ARST || m_phase == P_TX_DRST ||
                 m_phase == P_RX_ARST || m_phase == P_RX_DRST) begin
      if (m_age == RST_CYCLES - 1) nxt = m_phase + 1;
    end else if (m_phase == P_TX_WAIT) begin
      if (tx_pll_locked && !tx_cal_busy) nxt = P_TX_DRST; else if (deadline) want_retry = 1;
    end else if (m_phase == P_RX_WAIT) begin
      if (!rx_cal_busy && cdr_ok) nxt = P_RX_DRST; else if (deadline) want_retry = 1;
    end else if (m_phase == P_BLK_WAIT) begin
      if (blk_ok && m_run + 1 == STABLE_CYCLES) nxt = P_UP; else if (deadline) want_retry = 1;
    end else if (m_phase == P_UP) begin
`ifdef PR_HSSI_LINK_CTRL_AUTO_RECOVER_EN
      if (!blk_ok) nxt = P_RX_ARST;
`else
      if (!blk_ok) nxt = P_FAIL;
`endif
    end
    if (want_retry) begin
      if (m_retry < MAX_RETRY) begin
        m_retry = (m_retry + 1 > 3) ? 3 : m_retry + 1;
        nxt = P_TX_ARST;
      end else begin
        nxt = P_FAIL;
      end
    end
    if (nxt == P_IDLE) m_retry = 0;
    m_run   = (m_phase == P_BLK_WAIT && nxt == P_BLK_WAIT && blk_ok) ? m_run + 1 : 0;
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  task automatic cycle();
    @(posedge pClk);
    model_step();
    #1;
    cyc++;
    check("outs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic set_good();
    init_done = 1'b1; tx_pll_locked = 1'b1; tx_cal_busy = 1'b0; rx_cal_busy = 1'b0;
    rx_is_lockedtodata = 4'hF; rx_enh_blk_lock = 4'hF;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  task automatic run_until_state(input int s, input int bound, input string tag);
    int i;
    i = 0;
    while (state_o != 4'(s) && i < bound) begin cycle(); i++; end
    check(tag, 32'(state_o), 32'(s));
  endtask

  initial begin
    int t_arst, t_txa, t_up, i;
    bit saw_up, noisy;
    logic [3:0] v;

    // Reset state and nominal bring-up latency.
    start = 1'b0; set_good();
    do_reset(3);
    check("rst_state", 32'(state_o), 32'(P_IDLE));
    check("rst_resets", 32'({tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset}), 32'hF);
    check("rst_flags", 32'({link_up, link_fail, retry_cnt}), 32'h0);
    start = 1'b1;
    t_arst = -1; t_txa = -1; t_up = -1; i = 0;
    while (t_up < 0 && i < 100) begin
      cycle(); i++;
      if (t_arst < 0 && state_o == 4'(P_TX_ARST)) t_arst = cyc;
      if (t_arst >= 0 && t_txa < 0 && !tx_analogreset) t_txa = cyc;
      if (link_up) t_up = cyc;
    end
    check("txa_fall_lat", 32'(t_txa - t_arst), 32'(RST_CYCLES));
    check("link_up_lat", 32'(t_up - t_arst), 32'(4 * RST_CYCLES + 2 + STABLE_CYCLES));
    check("nominal_retry", 32'(retry_cnt), 32'd0);

    // Lock loss in UP.
    for (int k = 0; k < 3; k++) cycle();
    rx_enh_blk_lock = 4'b1011;
    cycle();
    rx_enh_blk_lock = 4'hF;
    check("loss_link_up", 32'(link_up), 32'd0);
`ifdef PR_HSSI_LINK_CTRL_AUTO_RECOVER_EN
    check("loss_state", 32'(state_o), 32'(P_RX_ARST));
    check("loss_txd", 32'(tx_digitalreset), 32'd0);
    run_until_state(P_UP, 60, "recover_up");
`else
    check("loss_state", 32'(state_o), 32'(P_FAIL));
    check("loss_fail", 32'(link_fail), 32'd1);
`endif
    do_reset(1);
    check("clear_fail", 32'(link_fail), 32'd0);
    check("clear_state", 32'(state_o), 32'(P_IDLE));

    // RX_WAIT timeout, then retries exhausted.
    rx_is_lockedtodata = 4'b0111;
    i = 0;
    while (retry_cnt != 2'd1 && i < 100) begin cycle(); i++; end
    check("tmo_retry", 32'(retry_cnt), 32'd1);
    check("tmo_state", 32'(state_o), 32'(P_TX_ARST));
    check("tmo_resets", 32'({tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset}), 32'hF);
    run_until_state(P_FAIL, 300, "tmo_fail_state");
    check("tmo_fail_flag", 32'(link_fail), 32'd1);
    set_good();
    do_reset(2);

    // Block lock dropping every 6th cycle never reaches UP; a steady run does.
    saw_up = 0;
    for (int k = 0; k < 200; k++) begin
      rx_enh_blk_lock = (k % 6 == 5) ? 4'b1110 : 4'hF;
      cycle();
      if (link_up) saw_up = 1;
    end
    check("toggle_no_up", 32'(saw_up), 32'd0);
    rx_enh_blk_lock = 4'hF;
    do_reset(1);
    run_until_state(P_UP, 60, "steady_up");
    check("steady_link_up", 32'(link_up), 32'd1);

    // Reset asserted in RX_DRST.
    do_reset(1);
    run_until_state(P_RX_DRST, 60, "reach_rx_drst");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_state", 32'(state_o), 32'(P_IDLE));
    check("midrst_resets", 32'({tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset}), 32'hF);

    // start dropped in TX_WAIT after one retry has been used.
    tx_pll_locked = 1'b0;
    i = 0;
    while (!(retry_cnt == 2'd1 && state_o == 4'(P_TX_WAIT)) && i < 100) begin cycle(); i++; end
    check("txwait_retry", 32'(retry_cnt), 32'd1);
    start = 1'b0;
    cycle();
    check("stop_state", 32'(state_o), 32'(P_IDLE));
    check("stop_retry", 32'(retry_cnt), 32'd0);
    set_good();
    start = 1'b1;

    // Randomized status traffic against the model.
    noisy = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) noisy = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 399) == 0) || (m_phase == P_FAIL && m_age > 10);
      start = ($urandom_range(0, 299) != 0);
      if (noisy) begin
        init_done     = ($urandom_range(0, 9) != 0);
        tx_pll_locked = ($urandom_range(0, 59) != 0);
        tx_cal_busy   = ($urandom_range(0, 5) == 0);
        rx_cal_busy   = ($urandom_range(0, 5) == 0);
        for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 19) != 0);
        rx_is_lockedtodata = v;
        for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 39) != 0);
        rx_enh_blk_lock = v;
      end else begin
        set_good();
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
